// File: rtl/smag_add_arbiter.sv
// Round-robin arbiter sharing one sign-magnitude add/subtract stage among NREQ requesters.
// Define SMAG_ADD_SAT_EN to saturate same-sign magnitude carries and flag them on ovf.
module smag_add_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 16,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] op_a,
  input  logic [NREQ*W-1:0] op_b,
  input  logic [NREQ-1:0]   neg_b,
  output logic [NREQ-1:0]   gnt,
  output logic [W-1:0]      res,
  output logic [IDW-1:0]    res_id,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              ovf
);

`ifdef SMAG_ADD_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [W-1:0]   cap_a;
  logic [W-1:0]   cap_b;
  logic [IDW-1:0] cap_id;

  logic           win_found;
  logic [IDW-1:0] win_id;
  logic           grant_ok;
  logic [W-1:0]   sel_a;
  logic [W-1:0]   eff_b;

  // First requesting index at or after the pointer, wrapping around.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
  end

  assign grant_ok = !rst && ((state == IDLE) || ((state == DONE) && res_ready));

  always_comb begin
    gnt = '0;
    if (grant_ok && win_found) gnt[win_id] = 1'b1;
  end

  assign sel_a = op_a[win_id*W +: W];
  assign eff_b = op_b[win_id*W +: W] ^ {neg_b[win_id], {(W-1){1'b0}}};

  logic           sa;
  logic           sb;
  logic [W-2:0]   ma;
  logic [W-2:0]   mb;
  logic           carry;
  logic [W-2:0]   mag_sum;
  logic [W-1:0]   calc_res;
  logic           calc_ovf;

  assign sa = cap_a[W-1];
  assign sb = cap_b[W-1];
  assign ma = cap_a[W-2:0];
  assign mb = cap_b[W-2:0];
  assign {carry, mag_sum} = {1'b0, ma} + {1'b0, mb};

  always_comb begin
    calc_res = '0;
    calc_ovf = 1'b0;
    if (sa == sb) begin
      if (SAT_EN && carry) begin
        calc_res = {sa, {(W-1){1'b1}}};
        calc_ovf = 1'b1;
      end else begin
        calc_res = {sa, mag_sum};
      end
    end else if (ma > mb) begin
      calc_res = {sa, ma - mb};
    end else if (mb > ma) begin
      calc_res = {sb, mb - ma};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cap_a     <= '0;
      cap_b     <= '0;
      cap_id    <= '0;
      res       <= '0;
      res_id    <= '0;
      res_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            cap_a  <= sel_a;
            cap_b  <= eff_b;
            cap_id <= win_id;
            ptr    <= (win_id == IDW'(NREQ-1)) ? '0 : win_id + 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          res       <= calc_res;
          res_id    <= cap_id;
          ovf       <= calc_ovf;
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (win_found) begin
              cap_a  <= sel_a;
              cap_b  <= eff_b;
              cap_id <= win_id;
              ptr    <= (win_id == IDW'(NREQ-1)) ? '0 : win_id + 1'b1;
              state  <= CALC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smag_add_arbiter.sv
// Scoreboard bench for smag_add_arbiter: stimulus pushes expected results, a monitor checks them.
module tb_smag_add_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int IDW  = 2;

`ifdef SMAG_ADD_SAT_EN
  localparam logic [W-1:0] OVF_RES  = 16'h7FFF;
  localparam logic         OVF_FLAG = 1'b1;
`else
  localparam logic [W-1:0] OVF_RES  = 16'h0000;
  localparam logic         OVF_FLAG = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] op_a;
  logic [NREQ*W-1:0] op_b;
  logic [NREQ-1:0]   neg_b;
  logic [NREQ-1:0]   gnt;
  logic [W-1:0]      res;
  logic [IDW-1:0]    res_id;
  logic              res_valid;
  logic              res_ready;
  logic              ovf;

  smag_add_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b), .neg_b(neg_b),
    .gnt(gnt), .res(res), .res_id(res_id), .res_valid(res_valid),
    .res_ready(res_ready), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]   r;
    logic [IDW-1:0] id;
    logic           o;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b, input logic n);
    op_a[idx*W +: W] = a;
    op_b[idx*W +: W] = b;
    neg_b[idx]       = n;
  endtask

  task automatic wait_gnt(input string name, input logic [NREQ-1:0] want);
    int n;
    n = 0;
    @(negedge clk);
    while (gnt == '0 && n < 20) begin
      tick();
      @(negedge clk);
      n++;
    end
    chk(name, 32'(gnt), 32'(want));
  endtask

  task automatic push(input logic [W-1:0] r, input int id, input logic o);
    exp_t e;
    e.r  = r;
    e.id = IDW'(id);
    e.o  = o;
    exp_q.push_back(e);
  endtask

  task automatic run_one(input string name, input int idx, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic n, input logic [W-1:0] r, input logic o);
    logic [NREQ-1:0] g;
    g      = '0;
    g[idx] = 1'b1;
    set_op(idx, a, b, n);
    req      = '0;
    req[idx] = 1'b1;
    wait_gnt({name, "_gnt"}, g);
    push(r, idx, o);
    tick();
    req = '0;
    @(negedge clk);
    chk({name, "_calc_valid"}, 32'(res_valid), 32'd0);
    tick();
    @(negedge clk);
    chk({name, "_valid"}, 32'(res_valid), 32'd1);
    tick();
  endtask

  // Monitor: every accepted result is matched against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && res_valid && res_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected: got res=%h id=%0d ovf=%0b with nothing expected", res, res_id, ovf);
      end else begin
        e = exp_q.pop_front();
        if (res !== e.r || res_id !== e.id || ovf !== e.o) begin
          errors++;
          $display("FAIL result: got res=%h id=%0d ovf=%0b expected res=%h id=%0d ovf=%0b",
                   res, res_id, ovf, e.r, e.id, e.o);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] fair_res [4];
    fair_res = '{16'h0011, 16'h0012, 16'h0013, 16'h0014};

    rst       = 1'b1;
    req       = 4'b1111;
    op_a      = '0;
    op_b      = '0;
    neg_b     = '0;
    res_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_valid", 32'(res_valid), 32'd0);
    chk("reset_res", 32'(res), 32'd0);
    chk("reset_id", 32'(res_id), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);
    req = '0;
    rst = 1'b0;
    tick();

    run_one("single", 0, 16'h0005, 16'h8003, 1'b0, 16'h0002, 1'b0);
    run_one("sub_zero", 2, 16'h0003, 16'h0003, 1'b1, 16'h0000, 1'b0);
    run_one("neg_add", 2, 16'h8004, 16'h8004, 1'b0, 16'h8008, 1'b0);
    run_one("sub_neg", 1, 16'h0002, 16'h0007, 1'b1, 16'h8005, 1'b0);
    run_one("overflow", 0, 16'h7FFF, 16'h0001, 1'b0, OVF_RES, OVF_FLAG);
    run_one("neg_zero", 3, 16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b0);

    // Pointer is back at 0 after the grant to requester 3.
    for (int i = 0; i < NREQ; i++) set_op(i, W'(i + 1), 16'h0010, 1'b0);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [NREQ-1:0] g;
      g          = '0;
      g[k % 4]   = 1'b1;
      wait_gnt("fair_gnt", g);
      push(fair_res[k % 4], k % 4, 1'b0);
      tick();
      @(negedge clk);
      chk("fair_calc_gnt", 32'(gnt), 32'd0);
      tick();
    end
    req = '0;
    @(negedge clk);
    tick();

    // Pointer is 1: grant 2 alone, leaving the pointer at 3 so 1 wins afterwards.
    set_op(2, 16'h0100, 16'h0023, 1'b0);
    req = 4'b0100;
    wait_gnt("bp_first_gnt", 4'b0100);
    push(16'h0123, 2, 1'b0);
    tick();
    req = 4'b0110;
    set_op(1, 16'h0001, 16'h8001, 1'b1);
    res_ready = 1'b0;
    @(negedge clk);
    chk("bp_calc_gnt", 32'(gnt), 32'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(res_valid), 32'd1);
      chk("bp_hold_res", 32'(res), 32'h0123);
      chk("bp_hold_id", 32'(res_id), 32'd2);
      chk("bp_hold_gnt", 32'(gnt), 32'd0);
      tick();
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_gnt", 32'(gnt), 32'b0010);
    push(16'h0002, 1, 1'b0);
    tick();
    req = '0;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("bp_second_valid", 32'(res_valid), 32'd1);
    tick();

    // Pointer is 2: requester 0 wins, then reset lands in its CALC cycle.
    set_op(0, 16'h0010, 16'h0001, 1'b0);
    req = 4'b0001;
    wait_gnt("rst_calc_gnt", 4'b0001);
    tick();
    req = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_cycle_gnt", 32'(gnt), 32'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("after_rst_valid", 32'(res_valid), 32'd0);
      chk("after_rst_res", 32'(res), 32'd0);
      chk("after_rst_id", 32'(res_id), 32'd0);
      chk("after_rst_ovf", 32'(ovf), 32'd0);
      chk("after_rst_gnt", 32'(gnt), 32'd0);
      tick();
    end

    // Pointer back at 0 means requester 0 beats 3; then 3 is granted normally.
    set_op(0, 16'h0001, 16'h0001, 1'b0);
    set_op(3, 16'h8005, 16'h0002, 1'b0);
    req = 4'b1001;
    wait_gnt("ptr_reset_gnt", 4'b0001);
    push(16'h0002, 0, 1'b0);
    tick();
    req = 4'b1000;
    @(negedge clk);
    chk("ptr_reset_calc_gnt", 32'(gnt), 32'd0);
    tick();
    @(negedge clk);
    chk("req3_gnt", 32'(gnt), 32'b1000);
    push(16'h8003, 3, 1'b0);
    tick();
    req = '0;
    tick();
    @(negedge clk);
    chk("req3_valid", 32'(res_valid), 32'd1);
    tick();
    tick();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/smag_add_arbiter.md
# smag_add_arbiter

Round-robin scheduler that shares one 16-bit sign-magnitude add/subtract datapath among `NREQ` requesters in the ZF detector (e.g. determinant and adjugate terms of the 2x2 channel inverse). It grants one request at a time, captures its operands, computes the result in a registered stage, and presents it with the requester ID under a valid/ready handshake.

## Interface
- `NREQ`, 4: number of requesters, at least 2.
- `W`, 16: word width, sign-magnitude. Bit `W-1` is the sign; bits `W-2:0` are the magnitude.
- `IDW`, `$clog2(NREQ)`: width of the result ID.

- `clk` in 1: single clock. Everything is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in `NREQ`: per-requester request level.
- `op_a` in `NREQ*W`: operand A. Requester i uses slice `[i*W +: W]`.
- `op_b` in `NREQ*W`: operand B, same packing as `op_a`.
- `neg_b` in `NREQ`: when set for requester i, B's sign is inverted before the add, giving A−B.
- `gnt` out `NREQ`: one-hot grant. Operands are captured on the clock edge that ends a `gnt` cycle.
- `res` out `W`: sign-magnitude result.
- `res_id` out `IDW`: index of the requester that owns `res`.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `ovf` out 1: magnitude overflow for the current result. Tied 0 unless the macro in Configuration is defined.

## Operation
- FSM has three states: IDLE, CALC and DONE. Reset state is IDLE.
  - IDLE: if any `req` is high, grant the winner, capture its A, effective B and ID, then go to CALC. Otherwise stay in IDLE.
  - CALC: compute the result into the output registers, set `res_valid`, then go to DONE.
  - DONE: hold `res`, `res_id`, `ovf` and `res_valid` stable until `res_ready` is high.
    - `res_ready` high with any `req` high: retire the result and grant a new request in the same cycle, then go to CALC.
    - `res_ready` high with no `req` high: go to IDLE.
- Arbitration:
  - Round-robin. The pointer names the highest-priority requester and resets to 0.
  - After a grant to requester i, the pointer becomes (i+1) mod `NREQ`.
  - `gnt` is decoded combinationally from `req` and the pointer, only in IDLE or in DONE with `res_ready` high. It is all-zero otherwise.
- Requester rules:
  - Hold `req` high and operands stable until `gnt[i]` is seen.
  - `req` may drop or change in the cycle after the grant.
  - Dropping `req` before the grant withdraws the request.
- Arithmetic on magnitudes mA, mB and signs sA, sB (sB already inverted when `neg_b` is set):
  - Same sign: sign = sA, magnitude = (mA+mB) mod 2^(W-1). So −0 + −0 gives `0x8000`.
  - Different signs, mA > mB: sign = sA, magnitude = mA−mB.
  - Different signs, mA < mB: sign = sB, magnitude = mB−mA.
  - Different signs, mA = mB: result is +0 (`0x0000`).
- Reset has priority in every state. Any in-flight operation is discarded with no result.
- Reset values:
  - FSM in IDLE, pointer 0.
  - `gnt` = 0, `res_valid` = 0.
  - `res` = 0, `res_id` = 0, `ovf` = 0.

## Timing
- Let T be the cycle in which `gnt` is high.
- CALC runs in T+1, and `res_valid` first rises in T+2. Latency from grant to result is 2 cycles.
- Back-to-back throughput, with `res_ready` held high and requests pending, is one result per 2 cycles.
- If `rst` is high in any cycle, all outputs equal their reset values in the next cycle. No grant is issued in a reset cycle.
- A request that arrives while in CALC or in DONE with `res_ready` low waits. It is considered at the next grant opportunity.

## Configuration
- Macro: `SMAG_ADD_SAT_EN`.
- Defined: on a same-sign magnitude carry, the magnitude saturates to all-ones (`0x7FFF` for W=16) and keeps the common sign. `ovf` is registered high alongside that result and is otherwise low.
- Undefined: the magnitude wraps modulo 2^(W-1) as stated in Operation, and `ovf` is constant 0.

## Test plan
- Single requester: req[0], A=`0x0005`, B=`0x8003`, neg_b=0. Expect gnt=`0001` in T; `res`=`0x0002`, `res_id`=0, `res_valid` in T+2.
- Subtract to zero: req[2], A=`0x0003`, B=`0x0003`, neg_b=1. Expect `res`=`0x0000` (+0). Then A=`0x8004`, B=`0x8004`, neg_b=0, expecting `0x8008`.
- Fairness: `req`=`1111` held, `res_ready`=1. Expect grants to requesters 0,1,2,3,0 in that order, every 2 cycles, each `res_id` matching its grant.
- Backpressure: `res_ready`=0 for 5 cycles after `res_valid` while `req`=`0110`. Expect `res` and `res_id` stable and `gnt`=0 throughout. On `res_ready`=1, expect gnt=`0010` in the same cycle.
- Overflow: A=`0x7FFF`, B=`0x0001`. Without the macro, expect `res`=`0x0000`, `ovf`=0. With `SMAG_ADD_SAT_EN`, expect `res`=`0x7FFF`, `ovf`=1.
- Reset in CALC: assert `rst` for one cycle in T+1. Expect `res_valid` never rises for that request, and all outputs and the pointer at reset values. The next `req`=`1000` is granted normally.
